temac_host_sequencer: RTL and testbench

- Controller for the TEMAC host management interface; drives the single HOST* port set of the TEMAC.
- Shares that port set between two independent requesters, e.g. a DCR bridge and a link-monitor FSM.
- Sequences two access types: configuration-register accesses (fixed read latency) and MIIM/MDIO accesses (variable latency, handshaked on HOSTMIIMRDY).
- Allows exactly one outstanding transaction. Responses are returned to the requester that issued the access.

---
 rtl/temac_host_pkg.sv | 31 +++
 rtl/temac_host_rr_arb.sv | 35 +++
 rtl/temac_host_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_temac_host_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temac_host_pkg.sv
// Shared types and constants for the TEMAC host-interface sequencer.
// Optional MIIM timeout abort is enabled with TEMAC_HOST_TIMEOUT_EN.
package temac_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG_ISSUE,
    CFG_WAIT,
    MIIM_ISSUE,
    MIIM_SETTLE,
    MIIM_WAIT,
    RESP
  } state_e;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  typedef struct packed {
    logic        miim;
    logic        emac1;
    logic [1:0]  opcode;
    logic [9:0]  addr;
    logic [31:0] wrdata;
  } host_req_t;

  // Only 2'b10 is a read; 2'b00 and 2'b11 are handled as writes.
  function automatic logic is_read(input logic [1:0] op);
    return op == OP_RD;
  endfunction

endpackage

// File: rtl/temac_host_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the
// non-granted requester whenever a grant is taken (advance_i).
module temac_host_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] elig_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    if (elig_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant_o = elig_i;
    end
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/temac_host_sequencer.sv
// Shares the TEMAC HOST* management port between two requesters, one
// transaction at a time. Define TEMAC_HOST_TIMEOUT_EN for MIIM timeout abort.
module temac_host_sequencer
  import temac_host_pkg::*;
#(
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned MIIM_TIMEOUT = 4095
) (
  input  logic        HOSTCLK,
  input  logic        RESET,
  input  logic        REQ0VALID,
  output logic        REQ0READY,
  input  logic        REQ0MIIM,
  input  logic        REQ0EMAC1,
  input  logic [1:0]  REQ0OPCODE,
  input  logic [9:0]  REQ0ADDR,
  input  logic [31:0] REQ0WRDATA,
  output logic        RSP0VALID,
  output logic [31:0] RSP0RDDATA,
  output logic        RSP0ERR,
  input  logic        REQ1VALID,
  output logic        REQ1READY,
  input  logic        REQ1MIIM,
  input  logic        REQ1EMAC1,
  input  logic [1:0]  REQ1OPCODE,
  input  logic [9:0]  REQ1ADDR,
  input  logic [31:0] REQ1WRDATA,
  output logic        RSP1VALID,
  output logic [31:0] RSP1RDDATA,
  output logic        RSP1ERR,
  output logic [1:0]  HOSTOPCODE,
  output logic [9:0]  HOSTADDR,
  output logic [31:0] HOSTWRDATA,
  output logic        HOSTREQ,
  output logic        HOSTMIIMSEL,
  output logic        HOSTEMAC1SEL,
  input  logic [31:0] HOSTRDDATA,
  input  logic        HOSTMIIMRDY
);

  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
    $error("RD_LATENCY must be in 1..7");
  end
  if (MIIM_TIMEOUT == 0 || MIIM_TIMEOUT > 4095) begin : g_bad_miim_timeout
    $error("MIIM_TIMEOUT must be in 1..4095");
  end

  state_e      state_q, state_d;
  host_req_t   req_q;
  host_req_t   req0_s, req1_s, sel_req;
  logic        owner_q;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] rd0_q, rd1_q;
  logic        cap_en;
  logic [31:0] cap_data;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        advance;
  logic [1:0]  ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  host_op;
  logic        rd_op;

`ifdef TEMAC_HOST_TIMEOUT_EN
  logic [11:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  assign req0_s  = {REQ0MIIM, REQ0EMAC1, REQ0OPCODE, REQ0ADDR, REQ0WRDATA};
  assign req1_s  = {REQ1MIIM, REQ1EMAC1, REQ1OPCODE, REQ1ADDR, REQ1WRDATA};
  assign sel_req = grant[1] ? req1_s : req0_s;

  // A busy MIIM engine makes only the MIIM requester ineligible, so a
  // pending config access on the other port still gets through.
  assign elig[0] = (state_q == IDLE) && !RESET && REQ0VALID && (!REQ0MIIM || HOSTMIIMRDY);
  assign elig[1] = (state_q == IDLE) && !RESET && REQ1VALID && (!REQ1MIIM || HOSTMIIMRDY);

  temac_host_rr_arb u_arb (
    .clk_i     (HOSTCLK),
    .rst_i     (RESET),
    .elig_i    (elig),
    .advance_i (advance),
    .grant_o   (grant)
  );

  assign rd_op   = is_read(req_q.opcode);
  assign host_op = rd_op ? OP_RD : OP_WR;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    cap_en       = 1'b0;
    cap_data     = '0;
    advance      = 1'b0;
    ready        = '0;
    rsp_valid    = '0;
    HOSTOPCODE   = '0;
    HOSTADDR     = '0;
    HOSTWRDATA   = '0;
    HOSTREQ      = 1'b0;
    HOSTMIIMSEL  = 1'b0;
    HOSTEMAC1SEL = 1'b0;
`ifdef TEMAC_HOST_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          advance = 1'b1;
          ready   = grant;
          state_d = sel_req.miim ? MIIM_ISSUE : CFG_ISSUE;
        end
      end
      CFG_ISSUE: begin
        HOSTOPCODE   = host_op;
        HOSTADDR     = req_q.addr;
        HOSTWRDATA   = req_q.wrdata;
        HOSTEMAC1SEL = req_q.emac1;
        if (rd_op) begin
          lat_d   = 3'(RD_LATENCY - 1);
          state_d = CFG_WAIT;
        end else begin
          state_d = RESP;
        end
      end
      CFG_WAIT: begin
        HOSTOPCODE   = host_op;
        HOSTADDR     = req_q.addr;
        HOSTEMAC1SEL = req_q.emac1;
        if (lat_q == 3'd0) begin
          cap_en   = 1'b1;
          cap_data = HOSTRDDATA;
          state_d  = RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      MIIM_ISSUE: begin
        HOSTREQ      = 1'b1;
        HOSTMIIMSEL  = 1'b1;
        HOSTOPCODE   = host_op;
        HOSTADDR     = req_q.addr;
        HOSTWRDATA   = {16'h0000, req_q.wrdata[15:0]};
        HOSTEMAC1SEL = req_q.emac1;
`ifdef TEMAC_HOST_TIMEOUT_EN
        tmo_d        = 12'(MIIM_TIMEOUT);
`endif
        state_d      = MIIM_SETTLE;
      end
      MIIM_SETTLE: begin
`ifdef TEMAC_HOST_TIMEOUT_EN
        tmo_d   = tmo_q - 12'd1;
`endif
        state_d = MIIM_WAIT;
      end
      MIIM_WAIT: begin
        if (HOSTMIIMRDY) begin
          cap_en   = rd_op;
          cap_data = {16'h0000, HOSTRDDATA[15:0]};
          state_d  = RESP;
`ifdef TEMAC_HOST_TIMEOUT_EN
        end else if (tmo_q == 12'd0) begin
          cap_en   = 1'b1;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          tmo_d = tmo_q - 12'd1;
`endif
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HOSTCLK) begin
    if (RESET) begin
      state_q <= IDLE;
      req_q   <= '0;
      owner_q <= 1'b0;
      lat_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
`ifdef TEMAC_HOST_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (advance) begin
        req_q   <= sel_req;
        owner_q <= grant[1];
      end
      if (cap_en) begin
        if (owner_q) begin
          rd1_q <= cap_data;
        end else begin
          rd0_q <= cap_data;
        end
      end
`ifdef TEMAC_HOST_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign REQ0READY  = ready[0];
  assign REQ1READY  = ready[1];
  assign RSP0VALID  = rsp_valid[0];
  assign RSP1VALID  = rsp_valid[1];
  assign RSP0RDDATA = rd0_q;
  assign RSP1RDDATA = rd1_q;
`ifdef TEMAC_HOST_TIMEOUT_EN
  assign RSP0ERR    = rsp_valid[0] & err_q;
  assign RSP1ERR    = rsp_valid[1] & err_q;
`else
  assign RSP0ERR    = 1'b0;
  assign RSP1ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_temac_host_sequencer.sv
// Directed bench for temac_host_sequencer; the timeout section is built
// only when TEMAC_HOST_TIMEOUT_EN is defined.
module tb_temac_host_sequencer;

  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] RD = 2'b10;
`ifdef TEMAC_HOST_TIMEOUT_EN
  localparam int unsigned TMO  = 16;
  localparam int unsigned HOLD = 10;
`else
  localparam int unsigned TMO  = 4095;
  localparam int unsigned HOLD = 40;
`endif

  logic        HOSTCLK = 1'b0;
  logic        RESET;
  logic        REQ0VALID, REQ0READY, REQ0MIIM, REQ0EMAC1;
  logic [1:0]  REQ0OPCODE;
  logic [9:0]  REQ0ADDR;
  logic [31:0] REQ0WRDATA;
  logic        RSP0VALID, RSP0ERR;
  logic [31:0] RSP0RDDATA;
  logic        REQ1VALID, REQ1READY, REQ1MIIM, REQ1EMAC1;
  logic [1:0]  REQ1OPCODE;
  logic [9:0]  REQ1ADDR;
  logic [31:0] REQ1WRDATA;
  logic        RSP1VALID, RSP1ERR;
  logic [31:0] RSP1RDDATA;
  logic [1:0]  HOSTOPCODE;
  logic [9:0]  HOSTADDR;
  logic [31:0] HOSTWRDATA;
  logic        HOSTREQ, HOSTMIIMSEL, HOSTEMAC1SEL;
  logic [31:0] HOSTRDDATA;
  logic        HOSTMIIMRDY;

  int n_chk  = 0;
  int n_fail = 0;

  temac_host_sequencer #(.RD_LATENCY(2), .MIIM_TIMEOUT(TMO)) dut (
    .HOSTCLK(HOSTCLK), .RESET(RESET),
    .REQ0VALID(REQ0VALID), .REQ0READY(REQ0READY), .REQ0MIIM(REQ0MIIM),
    .REQ0EMAC1(REQ0EMAC1), .REQ0OPCODE(REQ0OPCODE), .REQ0ADDR(REQ0ADDR),
    .REQ0WRDATA(REQ0WRDATA), .RSP0VALID(RSP0VALID), .RSP0RDDATA(RSP0RDDATA),
    .RSP0ERR(RSP0ERR),
    .REQ1VALID(REQ1VALID), .REQ1READY(REQ1READY), .REQ1MIIM(REQ1MIIM),
    .REQ1EMAC1(REQ1EMAC1), .REQ1OPCODE(REQ1OPCODE), .REQ1ADDR(REQ1ADDR),
    .REQ1WRDATA(REQ1WRDATA), .RSP1VALID(RSP1VALID), .RSP1RDDATA(RSP1RDDATA),
    .RSP1ERR(RSP1ERR),
    .HOSTOPCODE(HOSTOPCODE), .HOSTADDR(HOSTADDR), .HOSTWRDATA(HOSTWRDATA),
    .HOSTREQ(HOSTREQ), .HOSTMIIMSEL(HOSTMIIMSEL), .HOSTEMAC1SEL(HOSTEMAC1SEL),
    .HOSTRDDATA(HOSTRDDATA), .HOSTMIIMRDY(HOSTMIIMRDY)
  );

  always #5 HOSTCLK = ~HOSTCLK;

  task automatic tick();
    @(posedge HOSTCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic m, input logic e, input logic [1:0] op,
                          input logic [9:0] a, input logic [31:0] d);
    REQ0VALID = v; REQ0MIIM = m; REQ0EMAC1 = e; REQ0OPCODE = op; REQ0ADDR = a; REQ0WRDATA = d;
  endtask

  task automatic set_req1(input logic v, input logic m, input logic e, input logic [1:0] op,
                          input logic [9:0] a, input logic [31:0] d);
    REQ1VALID = v; REQ1MIIM = m; REQ1EMAC1 = e; REQ1OPCODE = op; REQ1ADDR = a; REQ1WRDATA = d;
  endtask

  task automatic wait_rsp(input int unsigned which, input int unsigned budget, output int unsigned cyc);
    cyc = 0;
    for (int unsigned i = 1; i <= budget; i++) begin
      tick();
      if ((which == 0 && RSP0VALID) || (which == 1 && RSP1VALID)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({HOSTREQ, HOSTMIIMSEL, HOSTEMAC1SEL, HOSTOPCODE, REQ0READY, REQ1READY,
                           RSP0VALID, RSP1VALID, RSP0ERR, RSP1ERR}), 32'h0);
    chk({tag, "_addr"}, 32'(HOSTADDR), 32'h0);
    chk({tag, "_wrdata"}, HOSTWRDATA, 32'h0);
    chk({tag, "_rd0"}, RSP0RDDATA, 32'h0);
    chk({tag, "_rd1"}, RSP1RDDATA, 32'h0);
  endtask

  initial begin
    int unsigned cyc;
    int          hreq;
    int          rsps;

    RESET = 1'b1;
    set_req0(0, 0, 0, 2'b00, '0, '0);
    set_req1(0, 0, 0, 2'b00, '0, '0);
    HOSTRDDATA  = '0;
    HOSTMIIMRDY = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    RESET = 1'b0;
    tick();

    // Simultaneous config writes right after reset: REQ0 first, then REQ1.
    set_req0(1, 0, 0, WR,    10'h011, 32'hA5A5_0001);
    set_req1(1, 0, 1, 2'b11, 10'h3F2, 32'h5A5A_0002);
    settle();
    chk("r1_ready", 32'({REQ0READY, REQ1READY}), 32'b10);
    tick(); REQ0VALID = 1'b0; settle();
    chk("r1_iss0_addr", 32'(HOSTADDR), 32'h011);
    chk("r1_iss0_wrdata", HOSTWRDATA, 32'hA5A5_0001);
    chk("r1_iss0_ctl", 32'({HOSTREQ, HOSTMIIMSEL, HOSTEMAC1SEL, HOSTOPCODE}), 32'b00001);
    chk("r1_busy_ready1", 32'(REQ1READY), 32'h0);
    tick();
    chk("r1_rsp0", 32'({RSP0VALID, RSP1VALID, RSP0ERR}), 32'b100);
    chk("r1_resp_host_idle", 32'({HOSTADDR, HOSTOPCODE}), 32'h0);
    tick();
    chk("r1_ready1", 32'({REQ0READY, REQ1READY}), 32'b01);
    tick(); REQ1VALID = 1'b0; settle();
    chk("r1_iss1", 32'({HOSTEMAC1SEL, HOSTOPCODE, HOSTADDR}), 32'({1'b1, 2'b01, 10'h3F2}));
    chk("r1_iss1_wrdata", HOSTWRDATA, 32'h5A5A_0002);
    tick();
    chk("r1_rsp1", 32'({RSP0VALID, RSP1VALID, RSP1ERR}), 32'b010);
    chk("r1_wr_no_rddata", RSP1RDDATA, 32'h0);
    tick();

    // Config read, RD_LATENCY=2: data presented only in the cycle before the sample edge.
    set_req0(1, 0, 0, RD, 10'h200, 32'h0);
    settle();
    chk("crd_ready", 32'({REQ0READY, REQ1READY}), 32'b10);
    tick(); REQ0VALID = 1'b0; settle();
    chk("crd_iss_addr", 32'(HOSTADDR), 32'h200);
    chk("crd_iss_ctl", 32'({HOSTREQ, HOSTMIIMSEL, HOSTOPCODE}), 32'b0010);
    tick();
    chk("crd_wait_addr", 32'(HOSTADDR), 32'h200);
    tick();
    chk("crd_no_early_rsp", 32'(RSP0VALID), 32'h0);
    HOSTRDDATA = 32'hDEAD_BEEF;
    wait_rsp(0, 10, cyc);
    HOSTRDDATA = 32'h0BAD_0BAD;
    chk("crd_latency_from_ready", 32'(3 + cyc), 32'd4);
    chk("crd_rddata", RSP0RDDATA, 32'hDEAD_BEEF);
    chk("crd_err_rsp1", 32'({RSP0ERR, RSP1VALID}), 32'b00);
    tick();
    HOSTRDDATA = '0;

    // Repeat of simultaneous writes: pointer now favours REQ1.
    set_req0(1, 0, 1, 2'b00, 10'h155, 32'h0000_1111);
    set_req1(1, 0, 0, WR,    10'h2AA, 32'h0000_2222);
    settle();
    chk("r2_ready", 32'({REQ0READY, REQ1READY}), 32'b01);
    tick(); REQ1VALID = 1'b0; settle();
    chk("r2_iss1_addr", 32'(HOSTADDR), 32'h2AA);
    tick();
    chk("r2_rsp1", 32'({RSP0VALID, RSP1VALID}), 32'b01);
    tick();
    chk("r2_ready0", 32'({REQ0READY, REQ1READY}), 32'b10);
    tick(); REQ0VALID = 1'b0; settle();
    chk("r2_iss0", 32'({HOSTEMAC1SEL, HOSTOPCODE, HOSTADDR}), 32'({1'b1, 2'b01, 10'h155}));
    tick();
    chk("r2_rsp0", 32'({RSP0VALID, RSP1VALID}), 32'b10);
    chk("r2_rd0_hold", RSP0RDDATA, 32'hDEAD_BEEF);
    tick();

    // MIIM read on REQ1 with a long busy period.
    set_req1(1, 1, 1, RD, {5'd1, 5'd2}, 32'h0);
    settle();
    chk("mrd_ready", 32'({REQ0READY, REQ1READY}), 32'b01);
    tick(); REQ1VALID = 1'b0; HOSTMIIMRDY = 1'b0; settle();
    chk("mrd_iss_ctl", 32'({HOSTREQ, HOSTMIIMSEL, HOSTEMAC1SEL, HOSTOPCODE}), 32'b11110);
    chk("mrd_iss_addr", 32'(HOSTADDR), 32'h022);
    hreq = int'(HOSTREQ);
    rsps = 0;
    for (int unsigned i = 0; i < HOLD; i++) begin
      tick();
      hreq += int'(HOSTREQ);
      rsps += int'(RSP0VALID) + int'(RSP1VALID);
    end
    HOSTMIIMRDY = 1'b1;
    HOSTRDDATA  = 32'hFFFF_796D;
    wait_rsp(1, 5, cyc);
    chk("mrd_rsp_latency", cyc, 32'd1);
    chk("mrd_rddata", RSP1RDDATA, 32'h0000_796D);
    chk("mrd_err", 32'(RSP1ERR), 32'h0);
    chk("mrd_hostreq_pulses", 32'(hreq), 32'd1);
    chk("mrd_no_early_rsp", 32'(rsps), 32'd0);
    chk("mrd_rd0_untouched", RSP0RDDATA, 32'hDEAD_BEEF);
    tick();
    HOSTRDDATA = '0;

    // MIIM busy: REQ0 MIIM must not block REQ1 config even though pointer favours REQ0.
    HOSTMIIMRDY = 1'b0;
    set_req0(1, 1, 0, WR, 10'h0C5, 32'h1234_ABCD);
    set_req1(1, 0, 0, WR, 10'h0F0, 32'hCAFE_F00D);
    settle();
    chk("byp_ready", 32'({REQ0READY, REQ1READY}), 32'b01);
    tick(); REQ1VALID = 1'b0; settle();
    chk("byp_iss1", 32'({HOSTMIIMSEL, HOSTADDR}), 32'({1'b0, 10'h0F0}));
    tick();
    chk("byp_rsp1", 32'({RSP0VALID, RSP1VALID}), 32'b01);
    rsps = 0;
    repeat (2) begin
      tick();
      rsps += int'(REQ0READY) + int'(REQ1READY);
    end
    chk("byp_hold_while_busy", 32'(rsps), 32'd0);
    HOSTMIIMRDY = 1'b1; settle();
    chk("byp_ready0", 32'({REQ0READY, REQ1READY}), 32'b10);
    tick(); REQ0VALID = 1'b0; settle();
    chk("byp_iss0_ctl", 32'({HOSTREQ, HOSTMIIMSEL, HOSTEMAC1SEL, HOSTOPCODE}), 32'b11001);
    chk("byp_iss0_wrdata", HOSTWRDATA, 32'h0000_ABCD);
    chk("byp_iss0_addr", 32'(HOSTADDR), 32'h0C5);
    wait_rsp(0, 10, cyc);
    chk("byp_rsp0_latency", cyc, 32'd3);
    chk("byp_wr_keeps_rd0", RSP0RDDATA, 32'hDEAD_BEEF);
    tick();

`ifdef TEMAC_HOST_TIMEOUT_EN
    // MIIM read that never completes: abort after MIIM_TIMEOUT=16.
    set_req0(1, 1, 0, RD, 10'h3E1, 32'h0);
    settle();
    chk("tmo_ready", 32'(REQ0READY), 32'h1);
    tick(); REQ0VALID = 1'b0; HOSTMIIMRDY = 1'b0;
    wait_rsp(0, 40, cyc);
    chk("tmo_latency", cyc, 32'd18);
    chk("tmo_err", 32'({RSP0ERR, RSP1VALID}), 32'b10);
    chk("tmo_rddata", RSP0RDDATA, 32'h0);
    tick();
    chk("tmo_after", 32'({RSP0VALID, RSP0ERR, HOSTREQ}), 32'b000);
    set_req1(1, 0, 0, WR, 10'h001, 32'h1);
    settle();
    chk("tmo_back_idle", 32'(REQ1READY), 32'h1);
    tick(); REQ1VALID = 1'b0;
    tick();
    chk("tmo_next_rsp1", 32'({RSP1VALID, RSP1ERR}), 32'b10);
    tick();
`endif

    // Reset during MIIM_WAIT: no response, everything back to reset values.
    HOSTMIIMRDY = 1'b1;
    set_req1(1, 1, 1, WR, 10'h3FF, 32'hFFFF_FFFF);
    settle();
    chk("rstw_ready", 32'(REQ1READY), 32'h1);
    tick(); REQ1VALID = 1'b0; HOSTMIIMRDY = 1'b0; settle();
    chk("rstw_hostreq", 32'(HOSTREQ), 32'h1);
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    chk_reset_outputs("rstw");
    RESET = 1'b0;
    HOSTMIIMRDY = 1'b1;
    rsps = 0;
    hreq = 0;
    repeat (6) begin
      tick();
      rsps += int'(RSP0VALID) + int'(RSP1VALID);
      hreq += int'(HOSTREQ);
    end
    chk("rstw_no_rsp", 32'(rsps), 32'd0);
    chk("rstw_no_hostreq", 32'(hreq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
